// File: rtl/arb_merge_pkg.sv
// Shared definitions for the N-to-1 arbitrating merge: arbitration mode
// encodings and a rotating first-one search reusable by other N-way arbiters.
package arb_merge_pkg;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // Widest request vector the search function handles.
    localparam int MAX_CH   = 16;
    localparam int MAX_ID_W = $clog2(MAX_CH);

    // Index of the first set bit of req[n-1:0], scanning start, start+1, ...
    // and wrapping modulo n. Returns 0 when nothing is set; callers qualify
    // the result with |req. start must be below n.
    function automatic int rot_first_one(input logic [MAX_CH-1:0] req,
                                         input int start,
                                         input int n);
        int   idx;
        logic found;
        rot_first_one = 0;
        found         = 1'b0;
        idx           = 0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < n) begin
                idx = start + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[MAX_ID_W-1:0]]) begin
                    rot_first_one = idx;
                    found         = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/cache_sync_fifo.sv
// Per-channel synchronous FIFO: single clock, power-of-two depth, pointers
// wrap naturally and a separate occupancy count distinguishes full from empty.
module cache_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  do_push;
    logic                  do_pop;

    // Full is judged on the registered count only, so a full FIFO refuses a
    // beat even in the cycle its head is being popped.
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: the data array has no reset; occupancy alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/arb_merge_rr_sync.sv
// N-to-1 arbitrating merge: one FIFO per input channel, a round-robin or
// fixed-priority arbiter, and a registered output stage carrying payload and
// source channel index.
module arb_merge_rr_sync
    import arb_merge_pkg::*;
#(
    parameter  int NUM_CH     = 8,
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 2,
    parameter  int ARB_MODE   = ARB_MODE_RR,
    localparam int ID_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            i_drive,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_free,
    output logic                         o_driveNext,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [ID_WIDTH-1:0]          o_src,
    input  logic                         i_freeNext,
    output logic                         o_busy
);

    logic [NUM_CH-1:0]     full_vec;
    logic [NUM_CH-1:0]     empty_vec;
    logic [NUM_CH-1:0]     nonempty;
    logic [NUM_CH-1:0]     push_vec;
    logic [NUM_CH-1:0]     pop_vec;
    logic [DATA_WIDTH-1:0] head [NUM_CH];
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   rr_next;
    logic [ID_WIDTH-1:0]   grant;
    logic                  any_req;
    logic                  load;

    assign nonempty = ~empty_vec;
    assign any_req  = |nonempty;
    assign o_free   = ~full_vec;
    assign push_vec = i_drive & ~full_vec;
    // The output stage can take a new beat when empty or when draining this cycle.
    assign load     = ~o_driveNext | i_freeNext;
    assign o_busy   = any_req | o_driveNext;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cache_sync_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (push_vec[i]),
            .pop   (pop_vec[i]),
            .wdata (i_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .full  (full_vec[i]),
            .empty (empty_vec[i]),
            .head  (head[i])
        );
    end

    // Grant selection: rotate from rr_ptr in round-robin mode, from 0 in fixed mode.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        pop_vec = '0;
        grant   = ID_WIDTH'(rot_first_one(MAX_CH'(nonempty),
                                          (ARB_MODE == ARB_MODE_FIXED) ? 0 : int'(rr_ptr),
                                          NUM_CH));
        rr_next = (grant == ID_WIDTH'(NUM_CH - 1)) ? '0 : grant + ID_WIDTH'(1);
        if (load && any_req) pop_vec[grant] = 1'b1;
    end

    // Round-robin pointer advances past the winner on every accepted grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (ARB_MODE == ARB_MODE_RR && load && any_req) begin
            rr_ptr <= rr_next;
        end
    end

    // Output stage: reload on load, otherwise hold payload and source stable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_driveNext <= 1'b0;
            o_data      <= '0;
            o_src       <= '0;
        end else if (load) begin
            if (any_req) begin
                o_driveNext <= 1'b1;
                o_data      <= head[grant];
                o_src       <= grant;
            end else begin
                o_driveNext <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_merge_rr_sync.sv
// Self-checking bench for arb_merge_rr_sync: a round-robin and a fixed-priority
// instance share the same stimulus and are compared every cycle against a
// queue-based reference model, with directed checks for the key scenarios.
module tb_arb_merge_rr_sync;

    localparam int NUM_CH = 8;
    localparam int DW     = 8;
    localparam int DEPTH  = 2;
    localparam int IDW    = $clog2(NUM_CH);

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NUM_CH-1:0]      in_drive;
    logic [NUM_CH*DW-1:0]   in_data;
    logic                   free_next;

    logic [NUM_CH-1:0]      rr_free,  fx_free;
    logic                   rr_valid, fx_valid;
    logic [DW-1:0]          rr_data,  fx_data;
    logic [IDW-1:0]         rr_src,   fx_src;
    logic                   rr_busy,  fx_busy;

    always #5 clk = ~clk;

    arb_merge_rr_sync #(
        .NUM_CH (NUM_CH), .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .ARB_MODE (0)
    ) dut_rr (
        .clk (clk), .rstn (rstn), .i_drive (in_drive), .i_data (in_data),
        .o_free (rr_free), .o_driveNext (rr_valid), .o_data (rr_data),
        .o_src (rr_src), .i_freeNext (free_next), .o_busy (rr_busy)
    );

    arb_merge_rr_sync #(
        .NUM_CH (NUM_CH), .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .ARB_MODE (1)
    ) dut_fx (
        .clk (clk), .rstn (rstn), .i_drive (in_drive), .i_data (in_data),
        .o_free (fx_free), .o_driveNext (fx_valid), .o_data (fx_data),
        .o_src (fx_src), .i_freeNext (free_next), .o_busy (fx_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: index 0 = round-robin instance, 1 = fixed priority.
    logic [DW-1:0] mq [2*NUM_CH][$];
    logic          mvalid [2];
    logic [DW-1:0] mdata  [2];
    int            msrc   [2];
    int            mrr;
    string         mname  [2] = '{"rr", "fx"};

    function automatic int qi(input int m, input int c);
        return m * NUM_CH + c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2*NUM_CH; i++) mq[i].delete();
        for (int m = 0; m < 2; m++) begin
            mvalid[m] = 1'b0;
            mdata[m]  = '0;
            msrc[m]   = 0;
        end
        mrr = 0;
    endtask

    task automatic compare();
        logic [NUM_CH-1:0] free_o, free_e;
        logic              valid_o, busy_o, busy_e;
        logic [DW-1:0]     data_o;
        logic [IDW-1:0]    src_o;
        for (int m = 0; m < 2; m++) begin
            free_o  = (m == 0) ? rr_free  : fx_free;
            valid_o = (m == 0) ? rr_valid : fx_valid;
            data_o  = (m == 0) ? rr_data  : fx_data;
            src_o   = (m == 0) ? rr_src   : fx_src;
            busy_o  = (m == 0) ? rr_busy  : fx_busy;
            busy_e  = mvalid[m];
            for (int c = 0; c < NUM_CH; c++) begin
                free_e[c] = (mq[qi(m, c)].size() < DEPTH);
                if (mq[qi(m, c)].size() != 0) busy_e = 1'b1;
            end
            check({mname[m], " valid"}, 32'(valid_o), 32'(mvalid[m]));
            check({mname[m], " data"},  32'(data_o),  32'(mdata[m]));
            check({mname[m], " src"},   32'(src_o),   32'(msrc[m]));
            check({mname[m], " free"},  32'(free_o),  32'(free_e));
            check({mname[m], " busy"},  32'(busy_o),  32'(busy_e));
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit acc [NUM_CH];
        int g;
        int c;
        if (!rstn) return;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NUM_CH; k++)
                acc[k] = in_drive[k] && (mq[qi(m, k)].size() < DEPTH);
            if (!mvalid[m] || free_next) begin
                g = -1;
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m == 0) ? (mrr + k) % NUM_CH : k;
                    if (g < 0 && mq[qi(m, c)].size() != 0) g = c;
                end
                if (g >= 0) begin
                    mdata[m]  = mq[qi(m, g)].pop_front();
                    msrc[m]   = g;
                    mvalid[m] = 1'b1;
                    if (m == 0) mrr = (g + 1) % NUM_CH;
                end else begin
                    mvalid[m] = 1'b0;
                end
            end
            for (int k = 0; k < NUM_CH; k++)
                if (acc[k]) mq[qi(m, k)].push_back(in_data[k*DW +: DW]);
        end
    endtask

    task automatic cycle();
        compare();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_drive = '0;
        repeat (n) cycle();
    endtask

    task automatic apply_reset(input int n);
        rstn = 1'b0;
        model_clear();
        #1;
        compare();
        @(negedge clk);
        repeat (n) cycle();
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        in_drive  = '0;
        in_data   = '0;
        free_next = 1'b1;
        model_clear();
        @(negedge clk);
        apply_reset(2);

        // Single beat on ch5: two-edge latency, then drains.
        in_drive = 8'h20;
        in_data[5*DW +: DW] = 8'hA5;
        cycle();
        in_drive = '0;
        check("t2 not yet valid", 32'(rr_valid), 32'd0);
        cycle();
        check("t2 valid", 32'(rr_valid), 32'd1);
        check("t2 data",  32'(rr_data),  32'hA5);
        check("t2 src",   32'(rr_src),   32'd5);
        cycle();
        check("t2 drained", 32'(rr_valid), 32'd0);

        // Reset mid-stream with three beats buffered discards everything.
        free_next = 1'b0;
        in_drive  = 8'b0000_1110;
        for (int c = 0; c < NUM_CH; c++) in_data[c*DW +: DW] = 8'(8'h30 + c);
        cycle();
        in_drive = '0;
        cycle();
        rstn = 1'b0;
        model_clear();
        #1;
        check("t1 rst valid", 32'(rr_valid), 32'd0);
        check("t1 rst data",  32'(rr_data),  32'd0);
        check("t1 rst src",   32'(rr_src),   32'd0);
        check("t1 rst busy",  32'(rr_busy),  32'd0);
        check("t1 rst free",  32'(rr_free),  32'hFF);
        @(negedge clk);
        cycle();
        rstn      = 1'b1;
        free_next = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t1 no stale beat", 32'(rr_valid), 32'd0);
        end

        // Preload every channel with two beats, then drain back-to-back.
        free_next = 1'b0;
        in_drive  = '1;
        for (int c = 0; c < NUM_CH; c++) in_data[c*DW +: DW] = 8'(8'h10 + c);
        cycle();
        cycle();
        in_drive  = '0;
        free_next = 1'b1;
        for (int i = 0; i < 2*NUM_CH; i++) begin
            check("t3 rr valid", 32'(rr_valid), 32'd1);
            check("t3 rr src",   32'(rr_src),   32'(i % NUM_CH));
            check("t3 rr data",  32'(rr_data),  32'(8'h10 + i % NUM_CH));
            check("t4 fx valid", 32'(fx_valid), 32'd1);
            check("t4 fx src",   32'(fx_src),   32'(i / 2));
            check("t4 fx data",  32'(fx_data),  32'(8'h10 + i / 2));
            cycle();
        end
        check("t3 rr empty", 32'(rr_valid), 32'd0);
        check("t4 fx empty", 32'(fx_valid), 32'd0);

        // Backpressure: output holds its first beat while ch1/ch3 fill up.
        apply_reset(1);
        free_next = 1'b0;
        in_drive  = 8'b0000_1010;
        for (int k = 0; k < 10; k++) begin
            in_data[1*DW +: DW] = 8'(8'h40 + k);
            in_data[3*DW +: DW] = 8'(8'h80 + k);
            if (k >= 2) begin
                check("t5 hold data", 32'(rr_data), 32'h40);
                check("t5 hold src",  32'(rr_src),  32'd1);
                check("t5 fx hold",   32'(fx_data), 32'h40);
            end
            cycle();
        end
        check("t5 ch1 full",  32'(rr_free[1]), 32'd0);
        check("t5 ch3 full",  32'(rr_free[3]), 32'd0);
        check("t5 ch0 free",  32'(rr_free[0]), 32'd1);
        free_next = 1'b1;
        idle(8);

        // Pointer wrap: ch6 sets rr_ptr to 7, then ch7 wins before ch0.
        in_drive = 8'h40;
        in_data[6*DW +: DW] = 8'hC6;
        cycle();
        idle(2);
        in_drive = 8'h81;
        in_data[0*DW +: DW] = 8'hC0;
        in_data[7*DW +: DW] = 8'hC7;
        cycle();
        in_drive = '0;
        cycle();
        check("t6 wrap src 7",  32'(rr_src),  32'd7);
        check("t6 wrap data 7", 32'(rr_data), 32'hC7);
        cycle();
        check("t6 wrap src 0",  32'(rr_src),  32'd0);
        check("t6 wrap data 0", 32'(rr_data), 32'hC0);
        idle(2);

        // Push into a full FIFO during a pop is refused without losing data.
        free_next = 1'b0;
        in_drive  = 8'h04;
        for (int k = 0; k < 3; k++) begin
            in_data[2*DW +: DW] = 8'(8'hD0 + k);
            cycle();
        end
        free_next = 1'b1;
        in_data[2*DW +: DW] = 8'hDF;
        check("t6 full refuses", 32'(rr_free[2]), 32'd0);
        cycle();
        in_drive = '0;
        check("t6 popped next", 32'(rr_data),    32'hD1);
        check("t6 slot freed",  32'(rr_free[2]), 32'd1);
        idle(4);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) apply_reset(2);
            in_drive = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) in_data[c*DW +: DW] = 8'($urandom);
            free_next = ($urandom_range(3, 0) != 0);
            cycle();
        end
        free_next = 1'b1;
        idle(20);
        check("final idle", 32'(rr_busy | fx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
